sync_filter: RTL and testbench

- Multi-channel input conditioner for asynchronous, slow or bouncy signals: pins, buttons, status lines from other domains.
- Each channel: parametrised-depth synchronizer chain, then a stability (glitch/debounce) filter.
- Optionally registered single-cycle rise/fall event pulses.
- Sits at the boundary between pads/foreign logic and the core clock domain; generalised successor of the plain flop-chain synchronizer.

---
 rtl/sync_filter_pkg.sv | 10 +
 rtl/sync_filter_chan.sv | 44 ++++
 rtl/sync_filter.sv | 44 ++++
 tb/tb_sync_filter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sync_filter_pkg.sv
// sync_filter_pkg: shared sizing helpers and parameter-legality rules for sync_filter.
package sync_filter_pkg;
  localparam int MIN_STAGES = 2;
  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles) > 1 ? $clog2(filter_cycles) : 1;
  endfunction
  function automatic bit params_ok(input int stages, input int filter_cycles);
    return stages >= MIN_STAGES && filter_cycles >= 1;
  endfunction
endpackage

// File: rtl/sync_filter_chan.sv
// sync_filter_chan: one-channel stability filter with optional rise/fall pulses (SYNC_FILTER_EDGE_EN).
module sync_filter_chan
  import sync_filter_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sy,
  output logic q,
  output logic pending,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);
  logic [CW-1:0] cnt;
  logic update;
  assign update  = (sy != q) && (cnt == CNT_MAX);
  assign pending = cnt != '0;
  // any return to q discards the run: no partial credit
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      q   <= RESET_VAL;
      cnt <= '0;
    end else begin
      q   <= update ? sy : q;
      cnt <= (sy == q || update) ? '0 : cnt + 1'b1;
    end
`ifdef SYNC_FILTER_EDGE_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= update & sy;
      fall <= update & ~sy;
    end
`else
  assign rise = 1'b0;
  assign fall = 1'b0;
`endif
endmodule

// File: rtl/sync_filter.sv
// sync_filter: per-channel flop-chain synchronizer followed by a debounce filter.
// Edge pulse outputs are live only when SYNC_FILTER_EDGE_EN is defined.
module sync_filter
  import sync_filter_pkg::*;
#(
  parameter int               WIDTH         = 1,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] pending,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);
  if (!params_ok(STAGES, FILTER_CYCLES)) begin : g_bad_params
    $error("sync_filter: STAGES must be >= %0d and FILTER_CYCLES >= 1", MIN_STAGES);
  end
  logic [WIDTH-1:0] s [STAGES];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) s[i] <= RESET_VAL;
    end else begin
      s[0] <= d;
      for (int i = 1; i < STAGES; i++) s[i] <= s[i-1];
    end
  for (genvar c = 0; c < WIDTH; c++) begin : g_chan
    sync_filter_chan #(
      .FILTER_CYCLES(FILTER_CYCLES),
      .RESET_VAL    (RESET_VAL[c])
    ) u_chan (
      .clk    (clk),
      .rst_n  (rst_n),
      .sy     (s[STAGES-1][c]),
      .q      (q[c]),
      .pending(pending[c]),
      .rise   (rise[c]),
      .fall   (fall[c])
    );
  end
endmodule

// File: tb/tb_sync_filter.sv
// tb_sync_filter: checks two sync_filter configurations against window-based reference models.
module tb_sync_filter;
`ifdef SYNC_FILTER_EDGE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif
  localparam logic [3:0] RA = 4'b1010;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0] d_a = 4'b0101, d_b = 4'b0000;
  logic [3:0] q_a, pending_a, rise_a, fall_a, q_b, pending_b, rise_b, fall_b;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;

  sync_filter #(.WIDTH(4), .STAGES(2), .FILTER_CYCLES(4), .RESET_VAL(RA)) dut_a (
    .clk(clk), .rst_n(rst_n), .d(d_a), .q(q_a), .pending(pending_a), .rise(rise_a), .fall(fall_a));
  sync_filter #(.WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VAL(4'b0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .d(d_b), .q(q_b), .pending(pending_b), .rise(rise_b), .fall(fall_b));

  // Reference: d is seen STAGES edges late; q flips when the last FILTER_CYCLES seen values all differ from it.
  logic [3:0] ma_dl[$], ma_win[$], ma_q, ma_p, ma_r, ma_f;
  logic [3:0] mb_dl[$], mb_win[$], mb_q, mb_p, mb_r, mb_f;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      ma_dl = '{RA, RA}; ma_win = '{RA, RA, RA, RA};
      ma_q = RA; ma_p = '0; ma_r = '0; ma_f = '0;
    end else begin : ma_step
      logic [3:0] sy;
      sy = ma_dl.pop_front(); ma_dl.push_back(d_a);
      void'(ma_win.pop_front()); ma_win.push_back(sy);
      for (int i = 0; i < 4; i++) begin
        bit all;
        all = 1'b1;
        foreach (ma_win[j]) if (ma_win[j][i] == ma_q[i]) all = 1'b0;
        ma_p[i] = (sy[i] != ma_q[i]) && !all;
        ma_r[i] = EDGE && all && sy[i];
        ma_f[i] = EDGE && all && !sy[i];
        if (all) ma_q[i] = sy[i];
      end
    end
  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mb_dl = '{4'h0, 4'h0, 4'h0}; mb_win = '{4'h0};
      mb_q = '0; mb_p = '0; mb_r = '0; mb_f = '0;
    end else begin : mb_step
      logic [3:0] sy;
      sy = mb_dl.pop_front(); mb_dl.push_back(d_b);
      void'(mb_win.pop_front()); mb_win.push_back(sy);
      for (int i = 0; i < 4; i++) begin
        bit all;
        all = 1'b1;
        foreach (mb_win[j]) if (mb_win[j][i] == mb_q[i]) all = 1'b0;
        mb_p[i] = (sy[i] != mb_q[i]) && !all;
        mb_r[i] = EDGE && all && sy[i];
        mb_f[i] = EDGE && all && !sy[i];
        if (all) mb_q[i] = sy[i];
      end
    end

  logic [31:0] act, expv;
  assign act  = {q_a, pending_a, rise_a, fall_a, q_b, pending_b, rise_b, fall_b};
  assign expv = {ma_q, ma_p, ma_r, ma_f, mb_q, mb_p, mb_r, mb_f};

  task automatic tick(input logic [3:0] a, input logic [3:0] b);
    d_a = a; d_b = b;
    @(negedge clk);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({q_a, pending_a, rise_a, fall_a, q_b, pending_b} !== {RA, 12'h000, 8'h00}) begin
      errors++; $display("FAIL reset_async got=%h exp=%h", {q_a, pending_a, rise_a, fall_a, q_b, pending_b}, {RA, 20'h0});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (act !== expv || q_a !== RA) begin errors++; $display("FAIL reset_hold got=%h exp=%h", act, expv); end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_settle;
    for (int k = 0; k < 10; k++) begin
      tick(4'b0000, 4'b0000);
      checks++;
      if (act !== expv) begin errors++; $display("FAIL settle k=%0d got=%h exp=%h", k, act, expv); end
    end
    checks++;
    if (q_a !== 4'b0000) begin errors++; $display("FAIL settle_q got=%b exp=0000", q_a); end
  endtask

  task automatic test_step;
    for (int k = 1; k <= 9; k++) begin
      tick(4'b0001, 4'b0000);
      checks++;
      if (act !== expv) begin errors++; $display("FAIL step_model k=%0d got=%h exp=%h", k, act, expv); end
      checks++;
      if ({q_a[0], pending_a[0], rise_a[0]} !== {k >= 6, k >= 3 && k <= 5, EDGE && k == 6}) begin
        errors++; $display("FAIL step_timing k=%0d got=%b exp=%b", k, {q_a[0], pending_a[0], rise_a[0]},
                           {k >= 6, k >= 3 && k <= 5, EDGE && k == 6});
      end
    end
  endtask

  task automatic test_glitch;
    bit saw_q, saw_p, saw_r;
    int hi, nr, nf;
    saw_q = 0; saw_p = 0; saw_r = 0; hi = 0; nr = 0; nf = 0;
    for (int k = 0; k < 11; k++) begin
      tick(k < 3 ? 4'b0011 : 4'b0001, 4'b0000);
      saw_q |= q_a[1]; saw_p |= pending_a[1]; saw_r |= rise_a[1];
      checks++;
      if (act !== expv) begin errors++; $display("FAIL glitch3 k=%0d got=%h exp=%h", k, act, expv); end
    end
    checks++;
    if ({saw_q, saw_p, saw_r, pending_a[1]} !== 4'b0100) begin
      errors++; $display("FAIL glitch3_summary got=%b exp=0100", {saw_q, saw_p, saw_r, pending_a[1]});
    end
    for (int k = 0; k < 14; k++) begin
      tick(k < 4 ? 4'b0011 : 4'b0001, 4'b0000);
      hi += q_a[1]; nr += rise_a[1]; nf += fall_a[1];
      checks++;
      if (act !== expv) begin errors++; $display("FAIL glitch4 k=%0d got=%h exp=%h", k, act, expv); end
    end
    checks++;
    if (hi != 4 || nr != int'(EDGE) || nf != int'(EDGE)) begin
      errors++; $display("FAIL glitch4_summary got hi=%0d rise=%0d fall=%0d exp hi=4 rise=%0d fall=%0d", hi, nr, nf, EDGE, EDGE);
    end
  endtask

  task automatic test_bounce;
    logic [8:0] seq;
    int nr;
    seq = 9'b111101101;
    nr = 0;
    for (int k = 0; k < 17; k++) begin
      tick({1'b0, k < 9 ? seq[k] : 1'b1, 2'b01}, 4'b0000);
      nr += rise_a[2];
      checks++;
      if (act !== expv) begin errors++; $display("FAIL bounce k=%0d got=%h exp=%h", k, act, expv); end
    end
    checks++;
    if (q_a[2] !== 1'b1 || nr != int'(EDGE)) begin
      errors++; $display("FAIL bounce_summary got q=%b rise=%0d exp q=1 rise=%0d", q_a[2], nr, EDGE);
    end
  endtask

  task automatic test_simultaneous;
    test_settle();
    for (int k = 1; k <= 10; k++) begin
      tick(k <= 2 ? 4'b0111 : 4'b1111, 4'b0000);
      checks++;
      if (act !== expv) begin errors++; $display("FAIL simul_model k=%0d got=%h exp=%h", k, act, expv); end
      if (k >= 5 && k <= 8) begin
        checks++;
        if (q_a !== (k == 5 ? 4'b0000 : k == 8 ? 4'b1111 : 4'b0111)) begin
          errors++; $display("FAIL simul_q k=%0d got=%b", k, q_a);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    bit got;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      tick(4'b1110, 4'b0000);
      got = pending_a[0];
    end
    checks++;
    if (!got) begin errors++; $display("FAIL reset_mid_wait got=pending0 never exp=pending0 set"); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pending_a !== 4'b0000 || q_a !== RA || act !== expv) begin
      errors++; $display("FAIL reset_mid got q=%b pend=%b exp q=%b pend=0000", q_a, pending_a, RA);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_settle();
  endtask

  task automatic test_degenerate;
    for (int k = 1; k <= 6; k++) begin
      tick(4'b0000, 4'b0001);
      checks++;
      if (act !== expv || q_b[0] !== (k >= 4) || pending_b !== 4'b0000) begin
        errors++; $display("FAIL degen_step k=%0d got q=%b pend=%b exp q0=%b", k, q_b, pending_b, k >= 4);
      end
    end
    for (int k = 1; k <= 6; k++) begin
      tick(4'b0000, k == 1 ? 4'b0011 : 4'b0001);
      checks++;
      if (act !== expv || q_b[1] !== (k == 4) || rise_b[1] !== (EDGE && k == 4) || pending_b !== 4'b0000) begin
        errors++; $display("FAIL degen_glitch k=%0d got q=%b rise=%b exp q1=%b", k, q_b, rise_b, k == 4);
      end
    end
  endtask

  task automatic test_random;
    logic [3:0] a;
    a = d_a;
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) if ($urandom_range(0, 4) == 0) a[i] = ~a[i];
      if (k == 200) begin #2 rst_n = 1'b0; end
      if (k == 202) rst_n = 1'b1;
      tick(a, 4'($urandom));
      checks++;
      if (act !== expv) begin errors++; $display("FAIL random k=%0d got=%h exp=%h", k, act, expv); end
    end
  endtask

  initial begin
    test_reset();
    test_settle();
    test_step();
    test_glitch();
    test_bounce();
    test_simultaneous();
    test_reset_mid();
    test_degenerate();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
